// File: rtl/crballoon_dl_loader_pkg.sv
// crballoon_dl_pkg: shared state type and constants for the download loader
package crballoon_dl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;
    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_DIP = 8'd254;
    localparam int CNT_W = 17;
endpackage

// File: rtl/crballoon_dl_loader_if.sv
// crballoon_dl_loader_if: HPS download stream in, ROM write port out
interface crballoon_dl_loader_if;
    logic        dn_ld;
    logic        dn_wr;
    logic [7:0]  dn_index;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        prog_we;
    logic        gfx_we;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    modport master(
        output dn_ld, dn_wr, dn_index, dn_addr, dn_data,
        input  prog_we, gfx_we, wr_addr, wr_data
    );
    modport slave(
        input  dn_ld, dn_wr, dn_index, dn_addr, dn_data,
        output prog_we, gfx_we, wr_addr, wr_data
    );
endinterface

// File: rtl/crballoon_dl_loader_dip_bank.sv
// crballoon_dip_bank: 8x8 DIP byte register file with flat 64-bit readout
module crballoon_dip_bank (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [7:0]  data,
    output logic [63:0] q
);
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (we) q[{addr, 3'b000} +: 8] <= data;
    end
endmodule

// File: rtl/crballoon_dl_loader.sv
// crballoon_dl_loader: HPS ROM/DIP download demux and core reset sequencer
module crballoon_dl_loader
    import crballoon_dl_pkg::*;
#(
    parameter logic [15:0]      PROG_END      = 16'h3000,
    parameter logic [15:0]      GFX_END       = 16'h3800,
    parameter logic [CNT_W-1:0] EXPECTED_LEN  = 17'h03800,
    parameter int               SETTLE_CYCLES = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 user_rst,
    crballoon_dl_loader_if.slave dl,
    output logic [63:0]          dipsw,
    output logic                 core_reset,
    output logic                 rom_ok,
    output logic                 rom_err
);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    state_t           state;
    logic             ld_q;
    logic [7:0]       cur_idx;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic [15:0]      settle;
    logic             rise, fall, fresh_rom, wr_ok, rom_wr, in_prog, in_gfx, dip_we, len_ok, ovf_nx;
    logic [7:0]       idx;
    logic [CNT_W-1:0] cnt_base, cnt_nx;
    always_comb begin
        rise      = dl.dn_ld & ~ld_q;
        fall      = ~dl.dn_ld & ld_q;
        fresh_rom = rise & (dl.dn_index == IDX_ROM);
        idx       = rise ? dl.dn_index : cur_idx;
        wr_ok     = dl.dn_wr & (dl.dn_ld | ld_q);
        rom_wr    = wr_ok & (idx == IDX_ROM);
        in_prog   = dl.dn_addr < PROG_END;
        in_gfx    = ~in_prog & (dl.dn_addr < GFX_END);
        dip_we    = wr_ok & (idx == IDX_DIP) & (dl.dn_addr[15:3] == 13'd0);
        cnt_base  = fresh_rom ? '0 : cnt;
        cnt_nx    = (rom_wr & ~&cnt_base) ? cnt_base + 17'd1 : cnt_base;
        ovf_nx    = (ovf & ~fresh_rom) | (rom_wr & ~in_prog & ~in_gfx);
        len_ok    = (cnt_nx == EXPECTED_LEN) & ~ovf_nx;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            ld_q       <= 1'b0;
            cur_idx    <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            settle     <= '0;
            dl.prog_we <= 1'b0;
            dl.gfx_we  <= 1'b0;
            dl.wr_addr <= '0;
            dl.wr_data <= '0;
            core_reset <= 1'b1;
            rom_ok     <= 1'b0;
            rom_err    <= 1'b0;
        end else begin
            ld_q       <= dl.dn_ld;
            cnt        <= cnt_nx;
            ovf        <= ovf_nx;
            dl.prog_we <= rom_wr & in_prog;
            dl.gfx_we  <= rom_wr & in_gfx;
            if (rom_wr & (in_prog | in_gfx)) begin
                dl.wr_addr <= in_prog ? dl.dn_addr : dl.dn_addr - PROG_END;
                dl.wr_data <= dl.dn_data;
            end
            if (rise) begin
                state      <= LOAD;
                cur_idx    <= dl.dn_index;
                core_reset <= 1'b1;
                if (fresh_rom) begin
                    rom_ok  <= 1'b0;
                    rom_err <= 1'b0;
                end
            end else begin
                case (state)
                    LOAD: if (fall) begin
                        settle <= SETTLE_LOAD;
                        if (cur_idx == IDX_ROM) begin
                            rom_ok  <= len_ok;
                            rom_err <= ~len_ok;
                            state   <= len_ok ? SETTLE : IDLE;
                        end else state <= rom_ok ? SETTLE : IDLE;
                    end
                    SETTLE: begin
                        settle <= user_rst ? SETTLE_LOAD : settle - 16'd1;
                        if (!user_rst && settle == 16'd0) begin
                            state      <= RUN;
                            core_reset <= 1'b0;
                        end
                    end
                    RUN: if (user_rst) begin
                        state      <= SETTLE;
                        settle     <= SETTLE_LOAD;
                        core_reset <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end
    crballoon_dip_bank u_dip (
        .clk  (CLK),
        .rst  (RESET),
        .we   (dip_we),
        .addr (dl.dn_addr[2:0]),
        .data (dl.dn_data),
        .q    (dipsw)
    );
endmodule

// File: tb/tb_crballoon_dl_loader.sv
// tb_crballoon_dl_loader: randomized download scenarios checked against a behavioural model
module tb_crballoon_dl_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        user_rst = 1'b0;
    logic [63:0] dipsw;
    logic        core_reset, rom_ok, rom_err;
    int          checks = 0;
    int          failures = 0;
    crballoon_dl_loader_if dl();
    crballoon_dl_loader dut (
        .CLK        (clk),
        .RESET      (rst),
        .user_rst   (user_rst),
        .dl         (dl),
        .dipsw      (dipsw),
        .core_reset (core_reset),
        .rom_ok     (rom_ok),
        .rom_err    (rom_err)
    );
    always #5 clk = ~clk;
    logic [25:0] exp_q[$];
    logic [25:0] obs_q[$];
    int          both_hi = 0;
    logic [7:0]  tb_idx = 8'd0;
    int          n_wr = 0;
    bit          ovf = 1'b0;
    bit          ok_m = 1'b0;
    logic [7:0]  dip_m [8];
    always @(negedge clk) begin
        if (dl.prog_we | dl.gfx_we) obs_q.push_back({dl.prog_we, dl.gfx_we, dl.wr_addr, dl.wr_data});
        if (dl.prog_we & dl.gfx_we) both_hi++;
    end
    function automatic logic [63:0] dip_flat();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = dip_m[i];
        return r;
    endfunction
    function automatic int stream_diff();
        int bad;
        bad = (exp_q.size() != obs_q.size()) ? 1 : 0;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (exp_q[i] !== obs_q[i]) bad++;
        return bad;
    endfunction
    function automatic int count_bit(input int b);
        int c;
        c = 0;
        foreach (obs_q[i]) if (obs_q[i][b]) c++;
        return c;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic ticks_to_release(input int start, output int n);
        n = start;
        while (core_reset === 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask
    task automatic start_load(input logic [7:0] idx);
        dl.dn_index = idx;
        dl.dn_ld = 1'b1;
        tb_idx = idx;
        if (idx == 8'd0) begin
            n_wr = 0;
            ovf = 1'b0;
        end
        exp_q.delete();
        obs_q.delete();
        tick();
        dl.dn_index = 8'($urandom);
    endtask
    task automatic write_byte(input logic [15:0] a, input logic [7:0] d, input bit last);
        dl.dn_addr = a;
        dl.dn_data = d;
        dl.dn_wr = 1'b1;
        if (last) dl.dn_ld = 1'b0;
        if (tb_idx == 8'd0) begin
            n_wr++;
            if (a < 16'h3000) exp_q.push_back({2'b10, a, d});
            else if (a < 16'h3800) exp_q.push_back({2'b01, 16'(a - 16'h3000), d});
            else ovf = 1'b1;
        end else if (tb_idx == 8'd254 && a < 16'd8) dip_m[a[2:0]] = d;
        tick();
        dl.dn_wr = 1'b0;
        dl.dn_addr = 16'($urandom);
        dl.dn_data = 8'($urandom);
        if (!last && $urandom_range(15) == 0) tick();
    endtask
    task automatic end_load();
        dl.dn_ld = 1'b0;
        tick();
    endtask
    task automatic test_reset();
        int bad;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) dip_m[i] = 8'h00;
        bad = 0;
        repeat (100) begin
            tick();
            if (core_reset !== 1'b1 || rom_ok !== 1'b0 || rom_err !== 1'b0 || dl.prog_we !== 1'b0 || dl.gfx_we !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL reset_idle_hold bad_cycles=%0d want=0", bad); end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL reset_core_reset got=%b want=1", core_reset); end
        checks++; if (rom_ok !== 1'b0 || rom_err !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b want=00", rom_ok, rom_err); end
        checks++; if (dipsw !== 64'd0) begin failures++; $display("FAIL reset_dipsw got=%h want=0", dipsw); end
        checks++; if (dl.wr_addr !== 16'd0 || dl.wr_data !== 8'd0) begin failures++; $display("FAIL reset_wr_bus got=%h/%h want=0/0", dl.wr_addr, dl.wr_data); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL reset_strobes got=%0d want=0", obs_q.size()); end
    endtask
    task automatic test_full_load(input bit last_on_fall);
        int n;
        start_load(8'd0);
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL full_load_hold got=%b want=1", core_reset); end
        for (int a = 0; a < 'h37FF; a++) write_byte(16'(a), 8'($urandom), 1'b0);
        if (last_on_fall) write_byte(16'h37FF, 8'($urandom), 1'b1);
        else begin
            write_byte(16'h37FF, 8'($urandom), 1'b0);
            end_load();
        end
        ok_m = (n_wr == 'h3800) && !ovf;
        ticks_to_release(1, n);
        checks++; if (n != 17) begin failures++; $display("FAIL full_release_cycles got=%0d want=17", n); end
        checks++; if (rom_ok !== ok_m) begin failures++; $display("FAIL full_rom_ok got=%b want=%b", rom_ok, ok_m); end
        checks++; if (rom_err !== 1'b0) begin failures++; $display("FAIL full_rom_err got=%b want=0", rom_err); end
        checks++; if (stream_diff() != 0) begin failures++; $display("FAIL full_stream diffs=%0d obs_n=%0d exp_n=%0d", stream_diff(), obs_q.size(), exp_q.size()); end
        checks++; if (count_bit(25) != 'h3000) begin failures++; $display("FAIL full_prog_count got=%0h want=3000", count_bit(25)); end
        checks++; if (count_bit(24) != 'h800) begin failures++; $display("FAIL full_gfx_count got=%0h want=800", count_bit(24)); end
        checks++; if (both_hi != 0) begin failures++; $display("FAIL strobe_overlap got=%0d want=0", both_hi); end
    endtask
    task automatic test_dip();
        int n;
        start_load(8'd254);
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL dip_hold got=%b want=1", core_reset); end
        write_byte(16'd0, 8'hA5, 1'b0);
        write_byte(16'd7, 8'h3C, 1'b0);
        write_byte(16'd8, 8'hFF, 1'b0);
        repeat (4) write_byte(16'($urandom_range(8, 65535)), 8'($urandom), 1'b0);
        end_load();
        ticks_to_release(1, n);
        checks++; if (n != 17) begin failures++; $display("FAIL dip_release_cycles got=%0d want=17", n); end
        checks++; if (dipsw !== dip_flat()) begin failures++; $display("FAIL dip_bank got=%h want=%h", dipsw, dip_flat()); end
        checks++; if (dipsw[7:0] !== 8'hA5 || dipsw[63:56] !== 8'h3C) begin failures++; $display("FAIL dip_bytes got=%h/%h want=a5/3c", dipsw[7:0], dipsw[63:56]); end
        checks++; if (rom_ok !== 1'b1) begin failures++; $display("FAIL dip_rom_ok got=%b want=1", rom_ok); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL dip_rom_strobes got=%0d want=0", obs_q.size()); end
    endtask
    task automatic test_user_rst();
        int n;
        user_rst = 1'b1;
        tick();
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL user_rst_assert got=%b want=1", core_reset); end
        tick();
        tick();
        user_rst = 1'b0;
        ticks_to_release(0, n);
        checks++; if (n != 16) begin failures++; $display("FAIL user_rst_release got=%0d want=16", n); end
    endtask
    task automatic test_load_during_settle();
        int n, bad;
        logic [63:0] dip_before;
        dip_before = dipsw;
        user_rst = 1'b1;
        tick();
        user_rst = 1'b0;
        repeat (5) tick();
        start_load(8'($urandom_range(1, 253)));
        repeat (5) write_byte(16'($urandom_range(0, 15)), 8'($urandom), 1'b0);
        bad = 0;
        repeat (20) begin
            tick();
            if (core_reset !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL settle_load_hold bad_cycles=%0d want=0", bad); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL other_idx_strobes got=%0d want=0", obs_q.size()); end
        checks++; if (dipsw !== dip_before) begin failures++; $display("FAIL other_idx_dip got=%h want=%h", dipsw, dip_before); end
        end_load();
        ticks_to_release(1, n);
        checks++; if (n != 17) begin failures++; $display("FAIL other_idx_release got=%0d want=17", n); end
    endtask
    task automatic test_short_load();
        int bad;
        start_load(8'd0);
        for (int a = 0; a < 'h3700; a++) write_byte(16'(a), 8'($urandom), 1'b0);
        end_load();
        ok_m = (n_wr == 'h3800) && !ovf;
        bad = 0;
        repeat (100) begin
            tick();
            if (core_reset !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL short_hold bad_cycles=%0d want=0", bad); end
        checks++; if (rom_ok !== ok_m) begin failures++; $display("FAIL short_rom_ok got=%b want=%b", rom_ok, ok_m); end
        checks++; if (rom_err !== !ok_m) begin failures++; $display("FAIL short_rom_err got=%b want=%b", rom_err, !ok_m); end
        checks++; if (stream_diff() != 0) begin failures++; $display("FAIL short_stream diffs=%0d obs_n=%0d exp_n=%0d", stream_diff(), obs_q.size(), exp_q.size()); end
    endtask
    task automatic test_overflow();
        int bad;
        start_load(8'd0);
        for (int a = 1; a < 'h3800; a++) write_byte(16'(a), 8'($urandom), 1'b0);
        write_byte(16'h3800, 8'($urandom), 1'b0);
        end_load();
        ok_m = (n_wr == 'h3800) && !ovf;
        bad = 0;
        repeat (30) begin
            tick();
            if (core_reset !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL ovf_hold bad_cycles=%0d want=0", bad); end
        checks++; if (rom_ok !== ok_m || rom_err !== !ok_m) begin failures++; $display("FAIL ovf_flags got=%b%b want=%b%b", rom_ok, rom_err, ok_m, !ok_m); end
        checks++; if (stream_diff() != 0) begin failures++; $display("FAIL ovf_stream diffs=%0d obs_n=%0d exp_n=%0d", stream_diff(), obs_q.size(), exp_q.size()); end
    endtask
    task automatic test_reset_mid_load();
        start_load(8'd0);
        for (int a = 0; a < 'h1000; a++) write_byte(16'(a), 8'($urandom), 1'b0);
        checks++; if (rom_err !== 1'b0 || rom_ok !== 1'b0) begin failures++; $display("FAIL load_entry_clear got=%b%b want=00", rom_ok, rom_err); end
        dl.dn_addr = 16'h1000;
        dl.dn_data = 8'($urandom);
        dl.dn_wr = 1'b1;
        rst = 1'b1;
        tick();
        checks++; if (dl.prog_we !== 1'b0 || dl.gfx_we !== 1'b0) begin failures++; $display("FAIL midrst_strobes got=%b%b want=00", dl.prog_we, dl.gfx_we); end
        checks++; if (dl.wr_addr !== 16'd0 || dl.wr_data !== 8'd0) begin failures++; $display("FAIL midrst_wr_bus got=%h/%h want=0/0", dl.wr_addr, dl.wr_data); end
        checks++; if (dipsw !== 64'd0) begin failures++; $display("FAIL midrst_dipsw got=%h want=0", dipsw); end
        checks++; if (core_reset !== 1'b1 || rom_ok !== 1'b0 || rom_err !== 1'b0) begin failures++; $display("FAIL midrst_flags got=%b%b%b want=100", core_reset, rom_ok, rom_err); end
        dl.dn_wr = 1'b0;
        dl.dn_ld = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) dip_m[i] = 8'h00;
        tick();
    endtask
    initial begin
        dl.dn_ld = 1'b0;
        dl.dn_wr = 1'b0;
        dl.dn_index = 8'd0;
        dl.dn_addr = 16'd0;
        dl.dn_data = 8'd0;
        test_reset();
        test_full_load(1'b1);
        test_dip();
        test_user_rst();
        test_load_during_settle();
        test_short_load();
        test_overflow();
        test_reset_mid_load();
        test_full_load(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/crballoon_dl_loader.md
Name: crballoon_dl_loader

Overview:
- Upstream stage for the Crazy Balloon core. Consumes the HPS download stream (data, address, write strobe, index, active flag).
- Demuxes ROM bytes into program and graphics write ports with one registered stage, and captures the MRA DIP bytes.
- Sequences the core reset: the core is held until a complete, correctly sized ROM image has loaded, then released after a settle delay.

Parameters:
- PROG_END, 16'h3000, first address past the program ROM region (program region = 0 .. PROG_END-1).
- GFX_END, 16'h3800, first address past the graphics ROM region (graphics region = PROG_END .. GFX_END-1).
- EXPECTED_LEN, 17'h03800, exact number of index-0 bytes required for a valid image.
- SETTLE_CYCLES, 16, number of CLK cycles core_reset stays high after a load or user reset; minimum 1.

Ports:
- CLK  in  1  system clock (clk_sys domain).
- RESET  in  1  synchronous, active-high system reset; clears all state.
- user_rst  in  1  OSD/button reset request; level-sensitive.
- dn_ld  in  1  download active.
- dn_wr  in  1  one-cycle byte-write strobe.
- dn_index  in  8  download index; 0 = ROM, 254 = DIP.
- dn_addr  in  16  byte address within the download.
- dn_data  in  8  download byte.
- prog_we  out  1  program ROM write enable.
- gfx_we  out  1  graphics ROM write enable.
- wr_addr  out  16  region-relative write address.
- wr_data  out  8  write byte.
- dipsw  out  64  DIP bytes 0..7; byte n sits at bits [8n+7:8n].
- core_reset  out  1  reset to the CRAZYBALLOON core.
- rom_ok  out  1  sticky flag: valid image loaded.
- rom_err  out  1  sticky flag: last ROM load was invalid.

Behaviour:
- Clock and reset are decided: one clock, CLK; reset RESET is synchronous and active-high.
- All outputs are registered. Reset values:
  - prog_we = gfx_we = 0; wr_addr = 0; wr_data = 0.
  - dipsw = 0; rom_ok = 0; rom_err = 0.
  - core_reset = 1; state = IDLE; byte counter = 0; settle counter = 0.
- dn_index is latched on the rising edge of dn_ld (cur_idx) and is ignored after that. dn_wr is ignored whenever dn_ld = 0.
- ROM write path (cur_idx = 0), latency 1 cycle from dn_wr:
  - dn_addr < PROG_END: prog_we = 1, wr_addr = dn_addr.
  - PROG_END <= dn_addr < GFX_END: gfx_we = 1, wr_addr = dn_addr - PROG_END.
  - dn_addr >= GFX_END: no strobe; set the overflow flag.
  - Each index-0 write increments the 17-bit byte counter, saturating at 17'h1FFFF.
  - Strobes last exactly one cycle. prog_we and gfx_we are never high together.
- DIP path (cur_idx = 254): on dn_wr with dn_addr[15:3] = 0, write byte dn_addr[2:0] of dipsw on the next cycle. Other addresses are ignored. No ROM strobe is generated.
- Any other index: writes are ignored; the state machine treats the load as a DIP-type load.
- State machine:
  - IDLE: core_reset = 1.
    - dn_ld rising -> LOAD.
  - LOAD: core_reset = 1.
    - On rising entry: if cur_idx = 0, clear the byte counter and overflow flag, and clear rom_ok and rom_err.
    - dn_ld falling with cur_idx = 0: if count = EXPECTED_LEN and no overflow, set rom_ok and go to SETTLE; otherwise set rom_err and go to IDLE.
    - dn_ld falling with cur_idx != 0: go to SETTLE if rom_ok, else IDLE.
  - SETTLE: core_reset = 1; the counter runs from SETTLE_CYCLES-1 down to 0, then -> RUN.
    - dn_ld rising -> LOAD (takes priority).
    - user_rst reloads the counter.
  - RUN: core_reset = 0.
    - dn_ld rising -> LOAD.
    - user_rst = 1 -> SETTLE with the counter reloaded.
- Simultaneous events:
  - dn_ld rising has priority over user_rst.
  - A dn_wr in the same cycle as the dn_ld falling edge is still written and counted before the length check.
- RESET mid-load: outputs return to reset values at once. Any partial image is abandoned; rom_ok = 0.
- core_reset falls exactly SETTLE_CYCLES cycles after the SETTLE entry cycle, provided no interruption occurs.

Decomposition:
- Package crballoon_dl_pkg holds:
  - state enum {IDLE, LOAD, SETTLE, RUN};
  - localparams IDX_ROM = 8'd0 and IDX_DIP = 8'd254;
  - the counter width (17).
- One natural sub-module, crballoon_dip_bank: 8x8 register file with a write port, a 3-bit address and a flat 64-bit output.
- The FSM, address decode and counters live in the top.

Test Plan:
- Power-on: RESET for 2 cycles, then idle for 100 cycles -> core_reset = 1, rom_ok = 0, rom_err = 0, no strobes.
- Full load, index 0, addresses 0..0x37FF, data = addr[7:0]:
  - prog_we pulses 0x3000 times with wr_addr 0..0x2FFF;
  - gfx_we pulses 0x800 times with wr_addr 0..0x7FF;
  - rom_ok = 1; core_reset falls exactly 16 cycles after the SETTLE entry cycle.
- Short load of 0x3700 bytes -> rom_err = 1, rom_ok = 0, core_reset stays 1. An extra byte at 0x3800 in an otherwise full load -> no strobe for it, rom_err = 1.
- DIP load after a good ROM, index 254, bytes 0xA5 at address 0 and 0x3C at address 7, plus 0xFF at address 8:
  - dipsw[7:0] = A5 and dipsw[63:56] = 3C; all other bytes 0;
  - rom_ok stays 1; core_reset pulses for 16 cycles, then is 0.
- In RUN, user_rst high for 3 cycles -> core_reset high until 16 cycles after user_rst falls. dn_ld rising during SETTLE -> enters LOAD, core_reset held.
- RESET asserted mid-load at address 0x1000 -> next cycle all outputs at reset values. A subsequent full load succeeds normally.
